// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Fetch/decode-side bus of the PC sequencer (selector, targets,
//               instruction fetch and IF/ID outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
   logic        stall;
   logic [1:0]  blinkctrl;
   logic [31:0] jr_target;
   logic [31:0] instr_in;
   logic [31:0] pc;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        pc_misalign;

   // master: hazard unit / decode resolver / instruction memory side
   modport master (
      output stall,
      output blinkctrl,
      output jr_target,
      output instr_in,
      input  pc,
      input  instr_d,
      input  pc_d,
      input  pc8_d,
      input  pc_misalign
   );

   // slave: the sequencer itself
   modport slave (
      input  stall,
      input  blinkctrl,
      input  jr_target,
      input  instr_in,
      output pc,
      output instr_d,
      output pc_d,
      output pc8_d,
      output pc_misalign
   );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : IF-stage PC and IF/ID register with delay-slot redirect.
//               Optional macro PC_ALIGN_CHECK_EN enables jr alignment fixup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  wire logic        clk,
   input  wire logic        reset,
   pc_sequencer_if.slave    bus
);

   localparam logic [1:0]  C_SEL_SEQ    = 2'd0;
   localparam logic [1:0]  C_SEL_BRANCH = 2'd1;
   localparam logic [1:0]  C_SEL_JUMP   = 2'd2;
   localparam logic [1:0]  C_SEL_JR     = 2'd3;
   localparam logic [31:0] C_FOUR       = 32'd4;
   localparam logic [31:0] C_EIGHT      = 32'd8;

   logic [31:0] r_pc;
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc8_d;

   logic [31:0] w_npc;
   logic [31:0] w_br_offset;
   logic        w_align_fault;

   assign w_br_offset = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};

   // Targets use the ID-stage PC; the slot instruction at pc_d+4 is already in IF.
   always_comb begin
      w_npc         = r_pc + C_FOUR;
      w_align_fault = 1'b0;
      case (bus.blinkctrl)
         C_SEL_SEQ:    w_npc = r_pc + C_FOUR;
         C_SEL_BRANCH: w_npc = r_pc_d + C_FOUR + w_br_offset;
         C_SEL_JUMP:   w_npc = {r_pc_d[31:28], r_instr_d[25:0], 2'b00};
         C_SEL_JR: begin
`ifdef PC_ALIGN_CHECK_EN
            if (bus.jr_target[1:0] != 2'b00) begin
               w_npc         = {bus.jr_target[31:2], 2'b00};
               w_align_fault = 1'b1;
            end else begin
               w_npc = bus.jr_target;
            end
`else
            w_npc = bus.jr_target;
`endif
         end
         default:      w_npc = r_pc + C_FOUR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_instr_d <= 32'h0;
         r_pc_d    <= 32'h0;
         r_pc8_d   <= 32'h0;
      end else if (!bus.stall) begin
         r_pc      <= w_npc;
         r_instr_d <= bus.instr_in;
         r_pc_d    <= r_pc;
         r_pc8_d   <= r_pc + C_EIGHT;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (!bus.stall && w_align_fault) begin
         r_misalign <= 1'b1;
      end
   end

   assign bus.pc_misalign = r_misalign;
`else
   logic w_unused;
   assign w_unused        = w_align_fault;
   assign bus.pc_misalign = 1'b0;
`endif

   assign bus.pc      = r_pc;
   assign bus.instr_d = r_instr_d;
   assign bus.pc_d    = r_pc_d;
   assign bus.pc8_d   = r_pc8_d;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed vector bench for pc_sequencer (both alignment builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   typedef struct {
      logic        reset;
      logic        stall;
      logic [1:0]  sel;
      logic [31:0] jr;
      logic [31:0] instr;
      logic [31:0] e_pc;
      logic [31:0] e_instr_d;
      logic [31:0] e_pc_d;
      logic [31:0] e_pc8_d;
      logic        e_mis;
   } vec_t;

   localparam logic [31:0] C_I0   = 32'h1111_1111;
   localparam logic [31:0] C_I1   = 32'h2222_2222;
   localparam logic [31:0] C_I2   = 32'h3333_3333;
   localparam logic [31:0] C_I3   = 32'h4444_4444;
   localparam logic [31:0] C_BEQ  = 32'h1000_FFFE;
   localparam logic [31:0] C_SLOT = 32'h5A5A_0001;
   localparam logic [31:0] C_J    = 32'h0800_0C10;
   localparam logic [31:0] C_SLT2 = 32'h6666_0002;
   localparam logic [31:0] C_IX   = 32'h7777_0000;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [31:0] C_JRPC = 32'h0000_4000;
   localparam logic        C_MIS  = 1'b1;
`else
   localparam logic [31:0] C_JRPC = 32'h0000_4002;
   localparam logic        C_MIS  = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   vec_t vecs[$];

   pc_sequencer_if bus ();

   pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic [1:0] sel,
                        input logic [31:0] jr, input logic [31:0] instr);
      reset         = r;
      bus.stall     = s;
      bus.blinkctrl = sel;
      bus.jr_target = jr;
      bus.instr_in  = instr;
   endtask

   task automatic add(input logic r, input logic s, input logic [1:0] sel,
                      input logic [31:0] jr, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] id,
                      input logic [31:0] pcd, input logic [31:0] pc8, input logic mis);
      vec_t v;
      v.reset = r; v.stall = s; v.sel = sel; v.jr = jr; v.instr = instr;
      v.e_pc = pc; v.e_instr_d = id; v.e_pc_d = pcd; v.e_pc8_d = pc8; v.e_mis = mis;
      vecs.push_back(v);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      drive(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);

      //   rst  stl  sel   jr            instr    pc            instr_d  pc_d          pc8_d         mis
      add(1'b1, 1'b0, 2'd0, 32'h0,        32'h0,   32'h3000,     32'h0,   32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 2'd0, 32'h0,        32'h0,   32'h3000,     32'h0,   32'h0,        32'h0,        1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I0,    32'h3004,     C_I0,    32'h3000,     32'h3008,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I1,    32'h3008,     C_I1,    32'h3004,     32'h300C,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I2,    32'h300C,     C_I2,    32'h3008,     32'h3010,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I3,    32'h3010,     C_I3,    32'h300C,     32'h3014,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_BEQ,   32'h3014,     C_BEQ,   32'h3010,     32'h3018,     1'b0);
      // taken branch, offset -8: slot still captured
      add(1'b0, 1'b0, 2'd1, 32'h0,        C_SLOT,  32'h300C,     C_SLOT,  32'h3014,     32'h301C,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I0,    32'h3010,     C_I0,    32'h300C,     32'h3014,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I1,    32'h3014,     C_I1,    32'h3010,     32'h3018,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I2,    32'h3018,     C_I2,    32'h3014,     32'h301C,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I3,    32'h301C,     C_I3,    32'h3018,     32'h3020,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_IX,    32'h3020,     C_IX,    32'h301C,     32'h3024,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_J,     32'h3024,     C_J,     32'h3020,     32'h3028,     1'b0);
      add(1'b0, 1'b0, 2'd2, 32'h0,        C_SLT2,  32'h3040,     C_SLT2,  32'h3024,     32'h302C,     1'b0);
      // jr held off by a two-cycle stall
      add(1'b0, 1'b1, 2'd3, 32'h4000,     C_I0,    32'h3040,     C_SLT2,  32'h3024,     32'h302C,     1'b0);
      add(1'b0, 1'b1, 2'd3, 32'h4000,     C_I0,    32'h3040,     C_SLT2,  32'h3024,     32'h302C,     1'b0);
      add(1'b0, 1'b0, 2'd3, 32'h4000,     C_I0,    32'h4000,     C_I0,    32'h3040,     32'h3048,     1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I1,    32'h4004,     C_I1,    32'h4000,     32'h4008,     1'b0);
      add(1'b1, 1'b1, 2'd2, 32'h0,        C_I2,    32'h3000,     32'h0,   32'h0,        32'h0,        1'b0);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I3,    32'h3004,     C_I3,    32'h3000,     32'h3008,     1'b0);
      // misaligned jr
      add(1'b0, 1'b0, 2'd3, 32'h4002,     C_I0,    C_JRPC,       C_I0,    32'h3004,     32'h300C,     C_MIS);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I1,    C_JRPC+32'd4, C_I1,    C_JRPC,       C_JRPC+32'd8, C_MIS);
      add(1'b0, 1'b1, 2'd3, 32'h4001,     C_I2,    C_JRPC+32'd4, C_I1,    C_JRPC,       C_JRPC+32'd8, C_MIS);
      // modulo-2^32 wrap of sequential increment
      add(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFC, C_I2,   32'hFFFF_FFFC, C_I2,   C_JRPC+32'd4, C_JRPC+32'd12, C_MIS);
      add(1'b0, 1'b0, 2'd0, 32'h0,        C_I3,    32'h0,        C_I3,    32'hFFFF_FFFC, 32'h4,       C_MIS);
      add(1'b1, 1'b0, 2'd0, 32'h0,        C_I0,    32'h3000,     32'h0,   32'h0,        32'h0,        1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].reset, vecs[i].stall, vecs[i].sel, vecs[i].jr, vecs[i].instr);
         @(posedge clk);
         #1;
         check32($sformatf("v%0d.pc", i),      bus.pc,          vecs[i].e_pc);
         check32($sformatf("v%0d.instr_d", i), bus.instr_d,     vecs[i].e_instr_d);
         check32($sformatf("v%0d.pc_d", i),    bus.pc_d,        vecs[i].e_pc_d);
         check32($sformatf("v%0d.pc8_d", i),   bus.pc8_d,       vecs[i].e_pc8_d);
         check1 ($sformatf("v%0d.misalign", i), bus.pc_misalign, vecs[i].e_mis);
      end

      // Back-to-back: j sits in the delay slot of a taken beq (+4 words)
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h1000_0004);
      @(posedge clk); #1;
      check32("b2b.seq_pc", bus.pc, 32'h3004);
      drive(1'b0, 1'b0, 2'd1, 32'h0, 32'h0800_0100);
      @(posedge clk); #1;
      check32("b2b.branch_pc", bus.pc, 32'h3014);
      check32("b2b.slot_instr", bus.instr_d, 32'h0800_0100);
      drive(1'b0, 1'b0, 2'd2, 32'h0, C_IX);
      @(posedge clk); #1;
      check32("b2b.jump_pc", bus.pc, 32'h0000_0400);
      check32("b2b.jump_pc_d", bus.pc_d, 32'h3014);

      // Positive branch offset across the 32-bit boundary
      drive(1'b0, 1'b0, 2'd3, 32'hFFFF_FFF8, C_IX);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h1000_0003);
      @(posedge clk); #1;
      check32("wrap.pc_d", bus.pc_d, 32'hFFFF_FFF8);
      drive(1'b0, 1'b0, 2'd1, 32'h0, C_I0);
      @(posedge clk); #1;
      check32("wrap.branch_pc", bus.pc, 32'h0000_0008);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter sequencer for the five-stage MIPS pipeline. It holds the IF-stage PC and the IF/ID pipeline register, and consumes the 2-bit next-PC selector that the decode-stage branch/jump resolver produces. Each cycle it commits PC+4, a branch target, a jump target or a register target, honouring the architectural delay slot. It also supplies the decode stage with the instruction, its PC and its link address (PC+8).

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk` input 1: pipeline clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: from hazard unit; freezes PC and IF/ID.
- `blinkctrl` input 2: next-PC select from decode resolver.
  - 0 = sequential.
  - 1 = taken branch.
  - 2 = j/jal.
  - 3 = jr/jalr.
- `jr_target` input 32: forwarded rs value for jr/jalr.
- `instr_in` input 32: instruction memory read data for the current `pc`.
- `pc` output 32: IF-stage PC, also the instruction memory address.
- `instr_d` output 32: IF/ID instruction.
- `pc_d` output 32: IF/ID PC.
- `pc8_d` output 32: IF/ID PC+8, the link value.
- `pc_misalign` output 1: sticky misaligned-jr flag (see Configuration).

## Operation
- Branch and jump fields come from the registered `instr_d`:
  - imm16 = `instr_d[15:0]`.
  - index26 = `instr_d[25:0]`.
- Target computation is combinational from `pc_d` (the PC of the branch/jump in ID):
  - sel 0: npc = `pc` + 4.
  - sel 1: npc = `pc_d` + 4 + (sign_extend(imm16) << 2).
  - sel 2: npc = {`pc_d`[31:28], index26, 2'b00}.
  - sel 3: npc = `jr_target`.
- Delay slot: when ID holds a control transfer, IF already holds the slot instruction at `pc_d`+4.
  - That instruction is captured into IF/ID normally and is never squashed.
  - The redirect only replaces the next fetch.
- All adders are 32-bit, modulo 2^32.
  - `pc` = 32'hFFFF_FFFC with sel 0 gives npc = 0.
  - Branch offsets wrap the same way.
- `stall`=1:
  - `pc`, `instr_d`, `pc_d` and `pc8_d` hold.
  - `blinkctrl` is ignored, because the ID operands are not yet valid.
  - The resolver re-evaluates on the cycle stall drops.
- `stall`=0:
  - `pc` <= npc.
  - `instr_d` <= `instr_in`.
  - `pc_d` <= `pc`.
  - `pc8_d` <= `pc` + 8.
- `reset` has priority over `stall` and over every `blinkctrl` value.
- Reset in the middle of a redirect discards the redirect; the next fetch is `RESET_PC`.
- No internal FSM beyond the registers. The effective states are RUN (stall=0) and HOLD (stall=1); transitions are driven solely by `stall`.

## Timing
- Reset values:
  - `pc` = `RESET_PC`.
  - `instr_d` = 32'h0 (nop).
  - `pc_d` = 0.
  - `pc8_d` = 0.
  - `pc_misalign` = 0.
- Redirect latency: `blinkctrl` is sampled in cycle N with stall=0, and `pc` equals the target after the edge ending cycle N.
  - One delay-slot fetch occurs in between; there is no bubble.
- Back-to-back redirects (control transfer in a delay slot): each is evaluated independently from its own `pc_d`. Behaviour is architecturally undefined, but it must be deterministic as specified.
- Outputs are registered only. `pc` drives instruction memory combinationally, with no extra stage.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - For sel 3 with stall=0, if `jr_target[1:0]` != 0, npc is forced to {`jr_target`[31:2], 2'b00}.
  - In that case `pc_misalign` sets at the same edge and stays 1 until reset.
- `PC_ALIGN_CHECK_EN` undefined:
  - `jr_target` is used verbatim.
  - `pc_misalign` is tied 0.

## Test plan
- **Reset and sequential fetch.** Reset for 2 cycles, then release with sel=0 for 3 cycles.
  - Required: `pc` = 3000, 3004, 3008, 300C.
  - Required: `pc_d` lags by one cycle; `pc8_d` = `pc_d`+8.
- **Taken branch with delay slot.** `instr_d` has imm16=16'hFFFE, `pc_d`=3010, sel=1.
  - Required: next `pc` = 300C.
  - Required: the slot instruction at 3014 still reaches `instr_d`.
- **j.** `pc_d`=3020, index26=26'h0000C10, sel=2.
  - Required: next `pc` = 0000_3040.
- **jr with stall.** sel=3, `jr_target`=0000_4000, stall=1 for 2 cycles, then 0.
  - Required: all outputs hold during the stall.
  - Required: `pc` = 4000 after the first unstalled edge.
- **Reset beats stall and redirect.** reset=1, stall=1, sel=2 all in the same cycle.
  - Required: `pc` = 3000 and `instr_d` = 0.
- **Alignment check, `PC_ALIGN_CHECK_EN` built.** `jr_target`=0000_4002, sel=3.
  - Required: `pc` = 4000 and `pc_misalign` = 1.
  - Required: the flag persists across a following sel=0 cycle.
- **Alignment check, `PC_ALIGN_CHECK_EN` not built.** Same stimulus.
  - Required: `pc` = 4002 and `pc_misalign` = 0.
